// File: rtl/ram_pkg.sv
// ram_pkg
// Shared constants and types for the 64x8 dual-port RAM test path.
// Both the write controller and the downstream read stage import this so the
// frame depth and the RAM geometry can never drift apart.
//   DEPTH    : words per frame, always 2**AW
//   AW / DW  : RAM address / data width
//   LAST_IDX : address of the final word of a frame
//   wr_state_t : write-controller state encoding
package ram_pkg;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  // Both counters wrap to zero on their own after this value because
  // DEPTH == 2**AW, so no explicit clear is needed at phase ends.
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } wr_state_t;

endpackage

// File: rtl/ram_wr_ctrl_if.sv
// ram_wr_ctrl_if
// Bundles the source handshake, the RAM port-A write bus and the status
// outputs of the write controller.
//   start       : one-cycle frame request
//   src_valid / src_data / src_ready : byte source handshake
//   ram_wr_en / ram_wr_addr / ram_wr_data : registered RAM write port
//   ram_rd_flag : contiguous read window for the read stage
//   busy / done / frame_cnt : status
// Modports:
//   master : the side that issues requests and bytes and observes status
//   slave  : the write controller itself
interface ram_wr_ctrl_if;
  import ram_pkg::*;

  logic          start;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_flag;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;

  modport master (
    output start, src_valid, src_data,
    input  src_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
    input  ram_rd_flag, busy, done, frame_cnt
  );

  modport slave (
    input  start, src_valid, src_data,
    output src_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
    output ram_rd_flag, busy, done, frame_cnt
  );

endinterface

// File: rtl/ram_wr_ctrl.sv
// ram_wr_ctrl
// Write-side controller of the RAM test path. Takes one frame of DEPTH bytes
// from a valid/ready source, writes them to RAM addresses 0..DEPTH-1, then
// holds ram_rd_flag high for exactly DEPTH cycles so the read stage sweeps the
// RAM once, pulses done and returns to idle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : ram_wr_ctrl_if.slave (handshake, RAM write port, status)
module ram_wr_ctrl
  import ram_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ram_wr_ctrl_if.slave   bus
);

  wr_state_t     state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          ready;
  logic          accept;

  // Status outputs come straight from the state register so that nothing
  // downstream sees a combinational path from the source inputs.
  assign ready           = (state_q == FILL);
  assign accept          = ready & bus.src_valid;

  assign bus.src_ready   = ready;
  assign bus.ram_rd_flag = (state_q == READ);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.frame_cnt   = frame_cnt_q;

  // State and datapath registers. Reset abandons any partial frame; the RAM
  // itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      rd_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state and datapath logic. Each accepted byte becomes a RAM write on
  // the following cycle; the write address/data hold their last value when
  // no write is issued, only the enable drops.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_cnt_d    = rd_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = FILL;
          wr_idx_d = '0;
          rd_cnt_d = '0;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_idx_q;
          wr_data_d = bus.src_data;
          wr_idx_d  = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // The window must stay contiguous: the read stage restarts at
        // address 0 whenever the flag is low.
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// tb_ram_wr_ctrl
// Self-checking bench for ram_wr_ctrl. A frame-level model (bytes accepted so
// far, read cycles elapsed, frames completed) predicts every output each cycle;
// a small RAM written from the DUT's write port is read back through the read
// window and compared with the bytes the model saw accepted. A few literal
// expectations pin the frame timing itself.
module tb_ram_wr_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_wr_ctrl_if bus ();

  ram_wr_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  bit checkEn = 1'b0;

  // Frame-level model state
  bit         mActive = 1'b0;
  int         mAccepted = 0;
  int         mReadCycles = 0;
  int         mFrameCnt = 0;
  bit         mWrEn = 1'b0;
  bit         mJustReset = 1'b0;
  int         mWrAddr = 0;
  int         mWrData = 0;
  logic [7:0] mMem [DEPTH];
  logic [7:0] tbRam [DEPTH];

  int writesSeen = 0;
  int rdHigh = 0;

  // Compare helper; every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.start     = s;
    bus.src_valid = v;
    bus.src_data  = d;
  endtask

  // Run random inputs until done is seen, with a cycle budget.
  task automatic waitDone(output int doneCyc);
    doneCyc = -1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 8'($urandom));
      if (bus.done === 1'b1) begin
        doneCyc = cycleCnt;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL done_timeout: got no done expected done within 300 cycles");
  endtask

  // Model: advance by one clock using the inputs the DUT sampled.
  always @(posedge clk) begin
    cycleCnt++;
    mWrEn = 1'b0;
    mJustReset = 1'b0;
    if (!rst_n) begin
      mActive = 1'b0;
      mAccepted = 0;
      mReadCycles = 0;
      mFrameCnt = 0;
      mWrAddr = 0;
      mWrData = 0;
      mJustReset = 1'b1;
    end else if (!mActive) begin
      if (bus.start) begin
        mActive = 1'b1;
        mAccepted = 0;
        mReadCycles = 0;
      end
    end else if (mAccepted < DEPTH) begin
      if (bus.src_valid) begin
        mWrEn = 1'b1;
        mWrAddr = mAccepted;
        mWrData = int'(bus.src_data);
        mMem[mAccepted] = bus.src_data;
        mAccepted++;
      end
    end else if (mReadCycles < DEPTH) begin
      mReadCycles++;
    end else begin
      mActive = 1'b0;
      mFrameCnt = (mFrameCnt + 1) % 65536;
    end
  end

  // RAM image built only from what the DUT actually writes.
  always @(posedge clk) begin
    if (bus.ram_wr_en === 1'b1) begin
      tbRam[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(bus.busy), 32'(mActive));
      checkOutput("src_ready", 32'(bus.src_ready), 32'(mActive && mAccepted < DEPTH));
      checkOutput("rd_flag", 32'(bus.ram_rd_flag),
                  32'(mActive && mAccepted == DEPTH && mReadCycles < DEPTH));
      checkOutput("done", 32'(bus.done),
                  32'(mActive && mAccepted == DEPTH && mReadCycles == DEPTH));
      checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(mFrameCnt));
      checkOutput("wr_en", 32'(bus.ram_wr_en), 32'(mWrEn));
      if (mWrEn || mJustReset) begin
        checkOutput("wr_addr", 32'(bus.ram_wr_addr), 32'(mWrAddr));
        checkOutput("wr_data", 32'(bus.ram_wr_data), 32'(mWrData));
      end
      if (mActive && mAccepted == DEPTH && mReadCycles < DEPTH) begin
        checkOutput("readback", 32'(tbRam[mReadCycles]), 32'(mMem[mReadCycles]));
      end
      if (bus.ram_wr_en === 1'b1) writesSeen++;
      if (bus.ram_rd_flag === 1'b1) rdHigh++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, d, accepts;
    int dc [3];

    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkEn = 1'b1;
    checkOutput("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.ram_wr_en), 32'd0);

    // src_valid while idle is never accepted
    writesSeen = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("idle_no_writes", 32'(writesSeen), 32'd0);

    // Continuous frame, data = index ^ 0xA5, random start during FILL/READ
    writesSeen = 0;
    rdHigh = 0;
    applyStimulus(1'b1, 1'b1, 8'h00);
    s = cycleCnt;
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'($urandom % 2), 1'b1, 8'(k) ^ 8'hA5);
    waitDone(d);
    checkOutput("cont_done_cycle", 32'(d - s), 32'd129);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("cont_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    checkOutput("cont_rd_window", 32'(rdHigh), 32'd64);
    checkOutput("cont_writes", 32'(writesSeen), 32'd64);
    checkOutput("cont_ram_5", 32'(tbRam[5]), 32'h0A0);
    checkOutput("cont_ram_63", 32'(tbRam[63]), 32'h09A);

    // Bubbly source: valid toggles 1/0
    writesSeen = 0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    accepts = 0;
    for (int i = 0; i < 400 && accepts < DEPTH; i++) begin
      applyStimulus(1'($urandom % 2), (i % 2) == 0, 8'($urandom));
      if ((i % 2) == 0) accepts++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bubbly_read_start", 32'(bus.ram_rd_flag), 32'd1);
    waitDone(d);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bubbly_writes", 32'(writesSeen), 32'd64);
    checkOutput("bubbly_frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Reset mid-FILL after 20 accepts
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("midreset_wr_en", 32'(bus.ram_wr_en), 32'd0);
    checkOutput("midreset_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'($urandom));
    checkOutput("restart_first_addr", 32'(bus.ram_wr_addr), 32'd0);
    checkOutput("restart_first_data", 32'(bus.ram_wr_data), 32'h3C);
    waitDone(d);

    // Back-to-back frames from a fresh reset
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom));
      for (int k = 0; k < DEPTH; k++) applyStimulus(1'b0, 1'b1, 8'($urandom));
      waitDone(dc[f]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("b2b_frame_cnt", 32'(bus.frame_cnt), 32'd3);
    checkOutput("b2b_gap_1", 32'(dc[1] - dc[0]), 32'd130);
    checkOutput("b2b_gap_2", 32'(dc[2] - dc[1]), 32'd130);

    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_wr_ctrl.md
# ram_wr_ctrl

Write-side controller for the 64×8 dual-port RAM test path. It accepts one frame of DEPTH bytes from a valid/ready source and writes them to consecutive RAM addresses 0..DEPTH-1. It then asserts `ram_rd_flag` for exactly DEPTH cycles, so the downstream read stage sweeps addresses 0..DEPTH-1 once. After that it pulses `done` and returns to idle.

## Interface
Parameters:
- `DEPTH`, 64: words per frame; must equal 2**AW.
- `AW`, 6: RAM address width.
- `DW`, 8: RAM data width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a frame; sampled only in IDLE.
- `src_valid`  in  1  source byte valid.
- `src_data`  in  DW  source byte.
- `src_ready`  out  1  controller accepts a byte this cycle.
- `ram_wr_en`  out  1  RAM port-A write enable, registered.
- `ram_wr_addr`  out  AW  RAM write address, registered.
- `ram_wr_data`  out  DW  RAM write data, registered.
- `ram_rd_flag`  out  1  read-window enable to the downstream read stage.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at frame end.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, FILL, READ, DONE; encoding is binary, held in one register.
- IDLE:
  - `src_ready`=0.
  - `start`=1 → FILL; write index `wr_idx` cleared to 0.
- FILL:
  - `src_ready`=1.
  - On accept (`src_valid & src_ready`), the next cycle has `ram_wr_en`=1, `ram_wr_addr`=`wr_idx`, `ram_wr_data`=`src_data`.
  - `wr_idx` increments by 1 per accept.
  - Idle cycles (`src_valid`=0) leave `wr_idx` unchanged and give `ram_wr_en`=0 the next cycle.
  - Accepting the beat at `wr_idx`=DEPTH-1 → READ; `wr_idx` wraps to 0 naturally (AW bits).
- READ:
  - `src_ready`=0; `ram_rd_flag`=1.
  - `rd_cnt` (AW bits) counts 0..DEPTH-1.
  - At `rd_cnt`=DEPTH-1 → DONE.
- DONE:
  - `done`=1; `frame_cnt` += 1.
  - Next state is IDLE unconditionally; `start` is ignored here.
- `start` outside IDLE has no effect.
- `src_valid` in IDLE/READ/DONE is never accepted.
- `busy` = (state != IDLE).
- `ram_rd_flag`, `src_ready`, `busy`, `done` are decoded from the state register only. They have no combinational path from inputs.
- Reset (any cycle, including mid-FILL/READ), values on the cycle after `rst_n`=0 is sampled:
  - state=IDLE; `wr_idx`=0; `rd_cnt`=0.
  - `ram_wr_en`=0, `ram_wr_addr`=0, `ram_wr_data`=0.
  - `frame_cnt`=0; all decoded outputs=0.
  - A partial frame is abandoned; RAM contents are not cleared.

## Timing
- Write latency: accept at cycle t → RAM write at t+1.
- Continuous source, `start` sampled at cycle 0:
  - FILL cycles 1..64, accepts 1..64, writes cycles 2..65.
  - READ cycles 65..128 (`ram_rd_flag` high exactly 64 cycles).
  - DONE cycle 129; IDLE cycle 130.
  - A new `start` can be sampled at cycle 130.
- Overlap on cycle 65:
  - The final write (addr DEPTH-1) coincides with the first read cycle (read addr 0).
  - Different addresses, so no collision; the read of addr DEPTH-1 occurs ≥63 cycles later.
- `ram_rd_flag` has no gaps inside READ. The downstream read stage resets its address whenever the flag is low, so the window must be contiguous.
- Minimum frame period with a continuous source: 2·DEPTH+2 cycles.

## Structure
- Shared package `ram_pkg`:
  - `DEPTH`, `AW`, `DW` constants, shared with the read stage.
  - State enum `wr_state_t` {IDLE, FILL, READ, DONE}.
- Single flat module; no sub-module is warranted. Counters and the FSM are small enough to inline.

## Test plan
- Continuous frame: `start` pulse, `src_valid`=1, `src_data`=index^0xA5.
  - Writes to addr k carry k^0xA5 for k=0..63.
  - `ram_rd_flag` high cycles 65..128; `done` at 129; `frame_cnt`=1.
- Bubbly source: `src_valid` toggles 1/0.
  - 64 writes with contiguous addresses 0..63 and no skipped or duplicated address.
  - READ starts the cycle after the 64th accept.
- Ignored requests: `start` during FILL and READ, and `src_valid` during IDLE/READ.
  - State sequence unchanged; no extra writes.
  - `src_ready`=0 outside FILL.
- Reset mid-FILL after 20 accepts.
  - All outputs 0 next cycle; `frame_cnt`=0.
  - A subsequent frame writes starting at addr 0.
- Back-to-back: three frames with `start` asserted on each first IDLE cycle.
  - `frame_cnt`=3; three `done` pulses 130 cycles apart.
- End-to-end with the read stage and the RAM: written pattern is read back in address order 0..63 during each READ window.
